// File: rtl/deinterleaver.sv
// -----------------------------------------------------------------------------
// deinterleaver
// Ping-pong block deinterleaver for OFDM coded bits. Received hard bits are
// written in arrival order into one of two Ncbps-bit banks; a completed bank
// is read back in original FEC order through the interleaver permutation j(k)
// while the other bank fills.
//
// Optional feature (macro DEINTERLEAVER_INDEX_OUT_EN): adds output
// data_out_index carrying the FEC-order index k of the bit on data_out.
//
// Ports
//   clk                 : clock, rising edge
//   reset               : asynchronous active-high reset
//   data_in             : received hard bit, arrival order
//   valid_demod         : data_in valid
//   ready_deinterleaver : block can accept data_in this cycle
//   data_out            : deinterleaved bit, original FEC order
//   valid_deinterleaver : data_out valid
//   data_out_index      : FEC index of data_out (DEINTERLEAVER_INDEX_OUT_EN only)
//   ready_fec_dec       : downstream decoder accepts data_out
// -----------------------------------------------------------------------------
module deinterleaver #(
    parameter int unsigned Ncbps = 192,
    parameter int unsigned Ncpc  = 2,
    parameter int unsigned s     = Ncpc / 2,
    parameter int unsigned d     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_in,
    input  logic                     valid_demod,
    output logic                     ready_deinterleaver,
    output logic                     data_out,
    output logic                     valid_deinterleaver,
`ifdef DEINTERLEAVER_INDEX_OUT_EN
    output logic [$clog2(Ncbps)-1:0] data_out_index,
`endif
    input  logic                     ready_fec_dec
);

    localparam int unsigned W    = $clog2(Ncbps);
    localparam int unsigned ROWS = Ncbps / d;
    localparam int unsigned STEP = (s == 0) ? 1 : s;
    localparam logic [W-1:0] LAST = W'(Ncbps - 1);

    // Bank states
    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] FILLING = 2'd1;
    localparam logic [1:0] FULL    = 2'd2;

    logic [1:0][Ncbps-1:0] mem;
    logic [1:0][1:0]       bank_state, bank_state_n;
    logic [W-1:0]          wr_cnt, wr_cnt_n;
    logic [W-1:0]          rd_cnt, rd_cnt_n;
    logic                  wr_bank, wr_bank_n;
    logic                  rd_bank, rd_bank_n;
    logic                  data_out_n;
    logic                  valid_n;
`ifdef DEINTERLEAVER_INDEX_OUT_EN
    logic [W-1:0]          index_n;
`endif

    logic                  wr_fire;
    logic                  rd_load;
    logic [31:0]           k_w;
    logic [31:0]           m_w;
    logic [W-1:0]          rd_addr;

    assign ready_deinterleaver = (bank_state[wr_bank] != FULL);
    assign wr_fire = valid_demod & ready_deinterleaver;
    assign rd_load = (bank_state[rd_bank] == FULL) & (~valid_deinterleaver | ready_fec_dec);

    // Read address j(k); 32-bit intermediates keep d*m from overflowing
    always_comb begin
        k_w     = 32'(rd_cnt);
        m_w     = ROWS * (k_w % d) + (k_w / d);
        rd_addr = W'(STEP * (m_w / STEP) + ((m_w + Ncbps - ((d * m_w) / Ncbps)) % STEP));
    end

    // Bank storage, not reset: contents are only trusted once a bank is FULL
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_cnt] <= data_in;
        end
    end

    // Next-state logic for counters, bank states and output register.
    // A bank finishing its write and the other finishing its read in the same
    // cycle touch different bank_state entries, so both updates land.
    always_comb begin
        wr_cnt_n     = wr_cnt;
        wr_bank_n    = wr_bank;
        rd_cnt_n     = rd_cnt;
        rd_bank_n    = rd_bank;
        bank_state_n = bank_state;
        data_out_n   = data_out;
        valid_n      = valid_deinterleaver;
`ifdef DEINTERLEAVER_INDEX_OUT_EN
        index_n      = data_out_index;
`endif

        if (wr_fire) begin
            if (wr_cnt == LAST) begin
                wr_cnt_n              = '0;
                bank_state_n[wr_bank] = FULL;
                wr_bank_n             = ~wr_bank;
            end else begin
                wr_cnt_n              = W'(wr_cnt + 1'b1);
                bank_state_n[wr_bank] = FILLING;
            end
        end

        if (rd_load) begin
            data_out_n = mem[rd_bank][rd_addr];
            valid_n    = 1'b1;
`ifdef DEINTERLEAVER_INDEX_OUT_EN
            index_n    = rd_cnt;
`endif
            if (rd_cnt == LAST) begin
                rd_cnt_n              = '0;
                bank_state_n[rd_bank] = EMPTY;
                rd_bank_n             = ~rd_bank;
            end else begin
                rd_cnt_n              = W'(rd_cnt + 1'b1);
            end
        end else if (valid_deinterleaver && ready_fec_dec) begin
            valid_n = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt              <= '0;
            wr_bank             <= 1'b0;
            rd_cnt              <= '0;
            rd_bank             <= 1'b0;
            bank_state          <= {EMPTY, EMPTY};
            data_out            <= 1'b0;
            valid_deinterleaver <= 1'b0;
`ifdef DEINTERLEAVER_INDEX_OUT_EN
            data_out_index      <= '0;
`endif
        end else begin
            wr_cnt              <= wr_cnt_n;
            wr_bank             <= wr_bank_n;
            rd_cnt              <= rd_cnt_n;
            rd_bank             <= rd_bank_n;
            bank_state          <= bank_state_n;
            data_out            <= data_out_n;
            valid_deinterleaver <= valid_n;
`ifdef DEINTERLEAVER_INDEX_OUT_EN
            data_out_index      <= index_n;
`endif
        end
    end

endmodule
